main_memory_model: RTL

- Behavioural main-memory slave sitting directly downstream of the data cache controller.
- Services line fills (MsRead) and write-through stores (MsWrite) over the MsRead/MsReady handshake, with a fixed, parameterised access latency.
- Address space matches the cache's {tag, index} block address plus a word offset. Used in cache-subsystem simulation and FPGA bring-up.

---
 rtl/main_memory_model.sv | 110 +++++++++++
 1 files changed

// File: rtl/main_memory_model.sv
// Behavioural main-memory slave for the data cache: fixed-latency line fills and
// single-word write-through stores over the MsRead/MsWrite/MsReady handshake.
module main_memory_model #(
    parameter int LATENCY    = 4,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MsRead,
    input  logic                         MsWrite,
    input  logic [ADDR_W-1:0]            MsAddr,
    input  logic [WORD_W-1:0]            MsWData,
    output logic                         MsReady,
    output logic [LINE_WORDS*WORD_W-1:0] MsRData,
    output logic                         MsBusy
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam int         OFF_W    = $clog2(LINE_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY, S_RELEASE} state_t;
    typedef logic [WORD_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) m[i] = WORD_W'(i);
        return m;
    endfunction

    mem_t mem = init_mem();

    state_t                         state, state_next;
    logic [3:0]                     cnt;
    logic                           op_read, op_write;
    logic [ADDR_W-1:0]              addr_q;
    logic [WORD_W-1:0]              wdata_q;
    logic [LINE_WORDS*WORD_W-1:0]   rdata;
    logic [LINE_WORDS*WORD_W-1:0]   line_data;
    logic                           req;

    assign req = MsRead || MsWrite;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Even LATENCY=1 passes through WAIT once so READY always follows edge k+LATENCY.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (req) state_next = S_WAIT;
            S_WAIT:    if (cnt == 4'd0) state_next = S_READY;
            S_READY:   state_next = S_RELEASE;
            S_RELEASE: if (!req) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        MsReady = (state == S_READY);
        MsBusy  = (state != S_IDLE);
    end

    always_comb begin
        line_data = '0;
        for (int w = 0; w < LINE_WORDS; w++)
            line_data[w*WORD_W +: WORD_W] = mem[{addr_q[ADDR_W-1:OFF_W], OFF_W'(w)}];
    end

    // A simultaneous read and write is treated as a read only.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            op_read  <= 1'b0;
            op_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                S_IDLE: if (req) begin
                    op_read  <= MsRead;
                    op_write <= MsWrite && !MsRead;
                    addr_q   <= MsAddr;
                    wdata_q  <= MsWData;
                    cnt      <= CNT_INIT;
                end
                S_WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    if (cnt == 4'd0 && op_read) rdata <= line_data;
                end
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset branch; reset must never disturb memory contents.
    always_ff @(posedge clk) begin
        if (!reset && state == S_READY && op_write)
            mem[addr_q] <= wdata_q;
    end

    assign MsRData = rdata;

endmodule
